// File: rtl/ece453_button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ece453_button_conditioner_pkg
//  Purpose  : State codes and helpers shared by the button conditioner and bench
//  Revision : 1.0
// ============================================================================
package ece453_button_conditioner_pkg;

  localparam int c_STATE_W = 3;

  // Codes are visible on current_state, so their values are fixed.
  typedef enum logic [c_STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_PRESSED    = 3'd2,
    ST_LONG_HELD  = 3'd3,
    ST_RELEASE_DB = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ece453_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module   : ece453_synchronizer
//  Purpose  : N-flop synchronizer for an asynchronous input, async reset to RESET_VAL
//  Revision : 1.0
// ============================================================================
module ece453_synchronizer
  import ece453_button_conditioner_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ece453_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : ece453_button_conditioner
//  Purpose  : Sync, debounce and short/long press classification of a raw button
//  Revision : 1.0
// ============================================================================
module ece453_button_conditioner
  import ece453_button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 64,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 button_raw,
  output logic                 button_press,
  output logic                 button_release,
  output logic                 long_press,
  output logic                 direction,
  output logic                 pressed,
  output logic [c_STATE_W-1:0] current_state
);

  localparam int                 c_CNT_W     = $clog2(max_int(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES));
  localparam logic [c_CNT_W-1:0] c_DB_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_LONG_LAST = c_CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic               c_RELEASED  = ACTIVE_LOW;

  logic               w_sync_out;
  logic               w_btn_s;
  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_press;
  logic               r_release;
  logic               r_long;
  logic               r_dir;
  logic               r_pressed;

  ece453_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (c_RELEASED)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (button_raw),
    .q     (w_sync_out)
  );

  // 1 = pressed regardless of pin polarity
  assign w_btn_s = w_sync_out ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_dir     <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (enable && w_btn_s) begin
            r_state <= ST_PRESS_DB;
          end
        end
        ST_PRESS_DB: begin
          if (!w_btn_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_state   <= ST_PRESSED;
            r_cnt     <= '0;
            r_press   <= 1'b1;
            r_pressed <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!w_btn_s) begin
            r_state <= ST_RELEASE_DB;
            r_cnt   <= '0;
          end else if (r_cnt == c_LONG_LAST) begin
            r_state <= ST_LONG_HELD;
            r_cnt   <= '0;
            r_long  <= 1'b1;
            r_dir   <= ~r_dir;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        ST_LONG_HELD: begin
          r_cnt <= '0;
          if (!w_btn_s) begin
            r_state <= ST_RELEASE_DB;
          end
        end
        ST_RELEASE_DB: begin
          // A bounce during release returns to LONG_HELD so no second long strobe can fire.
          if (w_btn_s) begin
            r_state <= ST_LONG_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_pressed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_pressed <= 1'b0;
        end
      endcase
    end
  end

  assign button_press   = r_press;
  assign button_release = r_release;
  assign long_press     = r_long;
  assign direction      = r_dir;
  assign pressed        = r_pressed;
  assign current_state  = r_state;

endmodule
`default_nettype wire
